// File: rtl/paddle_pkg.sv
// Shared types and helpers for the paddle pot sequencer.
// Holds the controller-mode and FSM encodings plus the saturating position step.
package paddle_pkg;

  typedef enum logic [1:0] {CM_DIGITAL, CM_Y, CM_X, CM_PADDLE} ctrl_mode_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT} fsm_state_e;

  localparam int unsigned POS_MAX = 255;
  localparam int unsigned CNT_W   = 9;

  // Step a digital position by one frame; computed in 9 bits so bit 8 flags over/underflow.
  function automatic logic [7:0] step_pos(input logic [7:0] pos, input logic [7:0] step,
                                          input logic up, input logic dn);
    logic [8:0] sum;
    logic [8:0] diff;
    sum  = {1'b0, pos} + {1'b0, step};
    diff = {1'b0, pos} - {1'b0, step};
    if (dn)
      step_pos = sum[8] ? 8'(POS_MAX) : sum[7:0];
    else if (up)
      step_pos = diff[8] ? '0 : diff[7:0];
    else
      step_pos = pos;
  endfunction

endpackage

// File: rtl/paddle_channel.sv
// One player's pot channel: position source mux, digital integrator and
// line counter that emulates the RC discharge of the paddle pot.
module paddle_channel
  import paddle_pkg::*;
#(
  parameter int unsigned POS_INIT = 128
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        load,
  input  logic        dec,
  input  logic [7:0]  step,
  input  logic [1:0]  mode,
  input  logic        inv,
  input  logic        up,
  input  logic        dn,
  input  logic [15:0] ana,
  input  logic [7:0]  pad,
  output logic [7:0]  pos,
  output logic        cnt_zero
);

  ctrl_mode_e       mode_e;
  logic [7:0]       src;
  logic [CNT_W-1:0] cnt;

  assign mode_e = ctrl_mode_e'(mode);

  // Signed stick axes become unsigned by flipping the sign bit.
  always_comb begin
    src = pos;
    unique case (mode_e)
      CM_DIGITAL: src = pos;
      CM_Y:       src = {~ana[15], ana[14:8]};
      CM_X:       src = {~ana[7], ana[6:0]};
      CM_PADDLE:  src = pad;
      default:    src = pos;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset)
      pos <= 8'(POS_INIT);
    else if (load && mode_e == CM_DIGITAL)
      pos <= step_pos(pos, step, up, dn);
  end

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (load)
      cnt <= {1'b0, src ^ {8{inv}}};
    else if (dec && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/paddle_pot_sequencer.sv
// Per-frame paddle pot scheduler for the AY-3-8500: loads both channels on
// vsync, counts hsync lines and drives the lpIN/rpIN comparator levels.
module paddle_pot_sequencer
  import paddle_pkg::*;
#(
  parameter int unsigned POS_INIT  = 128,
  parameter int unsigned STEP_SLOW = 5,
  parameter int unsigned STEP_FAST = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        hs,
  input  logic        vs,
  input  logic        speed,
  input  logic        practice,
  input  logic [1:0]  mode_p1,
  input  logic [1:0]  mode_p2,
  input  logic        inv_p1,
  input  logic        inv_p2,
  input  logic        up_p1,
  input  logic        dn_p1,
  input  logic        up_p2,
  input  logic        dn_p2,
  input  logic [15:0] ana_p1,
  input  logic [15:0] ana_p2,
  input  logic [7:0]  pad_p1,
  input  logic [7:0]  pad_p2,
  output logic        lp_in,
  output logic        rp_in,
  output logic [7:0]  pos_p1,
  output logic [7:0]  pos_p2,
  output logic        busy
);

  fsm_state_e state, state_next;
  logic       hs_r, vs_r;
  logic       hs_rise, vs_rise;
  logic       load, dec;
  logic [7:0] step;
  logic       zero_p1, zero_p2;
  logic       rp_raw;

  assign hs_rise = hs & ~hs_r;
  assign vs_rise = vs & ~vs_r;
  assign step    = speed ? 8'(STEP_FAST) : 8'(STEP_SLOW);
  assign load    = (state == S_LOAD);
  // A coincident vs rise reloads instead of decrementing.
  assign dec     = (state == S_COUNT) & hs_rise & ~vs_rise;

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      hs_r  <= 1'b0;
      vs_r  <= 1'b0;
      state <= S_IDLE;
    end else begin
      hs_r  <= hs;
      vs_r  <= vs;
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  state_next = S_IDLE;
      S_LOAD:  state_next = S_COUNT;
      S_COUNT: if (zero_p1 && zero_p2) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (vs_rise) state_next = S_LOAD;
  end

  paddle_channel #(.POS_INIT(POS_INIT)) u_ch_p1 (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .load     (load),
    .dec      (dec),
    .step     (step),
    .mode     (mode_p1),
    .inv      (inv_p1),
    .up       (up_p1),
    .dn       (dn_p1),
    .ana      (ana_p1),
    .pad      (pad_p1),
    .pos      (pos_p1),
    .cnt_zero (zero_p1)
  );

  paddle_channel #(.POS_INIT(POS_INIT)) u_ch_p2 (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .load     (load),
    .dec      (dec),
    .step     (step),
    .mode     (mode_p2),
    .inv      (inv_p2),
    .up       (up_p2),
    .dn       (dn_p2),
    .ana      (ana_p2),
    .pad      (pad_p2),
    .pos      (pos_p2),
    .cnt_zero (zero_p2)
  );

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      lp_in  <= 1'b1;
      rp_raw <= 1'b1;
    end else begin
      lp_in  <= zero_p1;
      rp_raw <= zero_p2;
    end
  end

  // Practice mode mirrors the already-registered left level so both sides match exactly.
  assign rp_in = practice ? lp_in : rp_raw;
  assign busy  = (state == S_COUNT) & ~(zero_p1 & zero_p2);

endmodule
